// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one adder among NUM_REQ requesters and
// returns {sum, carry, requester id, tag} through a 2-entry in-order FIFO.

module adder #(
    parameter int BIT_WIDTH  = 64,
    parameter int GATE_DELAY = 50,
    parameter     METHOD     = "RTL"
) (
    input  logic [BIT_WIDTH-1:0] in1,
    input  logic [BIT_WIDTH-1:0] in2,
    input  logic                 c_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 c_out
);
    // Behavioural add for RTL; an explicit ripple chain stands in for gate-level methods.
    if (METHOD == "RTL" || GATE_DELAY <= 0) begin : g_rtl
        assign {c_out, sum} = {1'b0, in1} + {1'b0, in2} + {{BIT_WIDTH{1'b0}}, c_in};
    end else begin : g_ripple
        logic [BIT_WIDTH:0] carry;
        assign carry[0] = c_in;
        for (genvar b = 0; b < BIT_WIDTH; b++) begin : g_bit
            assign sum[b]       = in1[b] ^ in2[b] ^ carry[b];
            assign carry[b + 1] = (in1[b] & in2[b]) | (carry[b] & (in1[b] ^ in2[b]));
        end
        assign c_out = carry[BIT_WIDTH];
    end
endmodule

module adder_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  BIT_WIDTH  = 64,
    parameter int  TAG_WIDTH  = 4,
    parameter int  GATE_DELAY = 50,
    parameter      METHOD     = "RTL",
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             reqValid,
    output logic [NUM_REQ-1:0]             reqReady,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   reqIn1,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   reqIn2,
    input  logic [NUM_REQ-1:0]             reqCIn,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   reqTag,
    output logic                           respValid,
    input  logic                           respReady,
    output logic [BIT_WIDTH-1:0]           respSum,
    output logic                           respCOut,
    output logic [ID_W-1:0]                respId,
    output logic [TAG_WIDTH-1:0]           respTag,
    output logic                           idle
);
    typedef struct packed {
        logic [BIT_WIDTH-1:0] sum;
        logic                 c_out;
        logic [ID_W-1:0]      id;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    logic [BIT_WIDTH-1:0] in1_arr [NUM_REQ];
    logic [BIT_WIDTH-1:0] in2_arr [NUM_REQ];
    logic [TAG_WIDTH-1:0] tag_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign in1_arr[i] = reqIn1[i*BIT_WIDTH +: BIT_WIDTH];
        assign in2_arr[i] = reqIn2[i*BIT_WIDTH +: BIT_WIDTH];
        assign tag_arr[i] = reqTag[i*TAG_WIDTH +: TAG_WIDTH];
    end

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant;
    logic [ID_W-1:0]      idx;
    logic                 any_valid;
    logic [1:0]           count;
    logic                 wr_ptr;
    logic                 rd_ptr;
    entry_t               mem [2];
    entry_t               head;
    logic                 push;
    logic                 pop;
    logic [BIT_WIDTH-1:0] add_sum;
    logic                 add_cout;

    // NOTE: every always_comb output gets a default before any conditional write,
    // otherwise the tool infers a latch for the paths that skip the assignment.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && reqValid[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

    adder #(
        .BIT_WIDTH  (BIT_WIDTH),
        .GATE_DELAY (GATE_DELAY),
        .METHOD     (METHOD)
    ) u_adder (
        .in1   (in1_arr[grant]),
        .in2   (in2_arr[grant]),
        .c_in  (reqCIn[grant]),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // Accept depends only on registered fill level, never on respReady.
    assign push     = any_valid && !count[1];
    assign pop      = (count != 2'd0) && respReady;
    assign reqReady = (push && rst_n) ? (NUM_REQ'(1) << grant) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the FIFO storage is reset too so no old result can
    // ever be observed after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            rr_ptr <= '0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{sum: add_sum, c_out: add_cout, id: grant, tag: tag_arr[grant]};
                wr_ptr      <= ~wr_ptr;
                rr_ptr      <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign respValid = (count != 2'd0);
    assign idle      = (count == 2'd0);
    assign respSum   = respValid ? head.sum   : '0;
    assign respCOut  = respValid ? head.c_out : 1'b0;
    assign respId    = respValid ? head.id    : '0;
    assign respTag   = respValid ? head.tag   : '0;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single-request vector table followed by
// arbitration, back-pressure, push/pop overlap and mid-stream reset sequences.

module tb_adder_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      reqValid;
    logic [N-1:0]      reqReady;
    logic [N*W-1:0]    reqIn1;
    logic [N*W-1:0]    reqIn2;
    logic [N-1:0]      reqCIn;
    logic [N*TW-1:0]   reqTag;
    logic              respValid;
    logic              respReady;
    logic [W-1:0]      respSum;
    logic              respCOut;
    logic [1:0]        respId;
    logic [TW-1:0]     respTag;
    logic              idle;

    logic [W-1:0]      in1_a [N];
    logic [W-1:0]      in2_a [N];
    logic [TW-1:0]     tag_a [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        reqIn1 = '0;
        reqIn2 = '0;
        reqTag = '0;
        for (int i = 0; i < N; i++) begin
            reqIn1[i*W +: W]   = in1_a[i];
            reqIn2[i*W +: W]   = in2_a[i];
            reqTag[i*TW +: TW] = tag_a[i];
        end
    end

    adder_arbiter #(
        .NUM_REQ   (N),
        .BIT_WIDTH (W),
        .TAG_WIDTH (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqIn1    (reqIn1),
        .reqIn2    (reqIn2),
        .reqCIn    (reqCIn),
        .reqTag    (reqTag),
        .respValid (respValid),
        .respReady (respReady),
        .respSum   (respSum),
        .respCOut  (respCOut),
        .respId    (respId),
        .respTag   (respTag),
        .idle      (idle)
    );

    typedef struct {
        int          req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [TW-1:0] tag;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        reqValid  = '0;
        respReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = '1;
        respReady = 1'b0;
        reqCIn    = '0;
        for (int i = 0; i < N; i++) begin
            in1_a[i] = '0;
            in2_a[i] = '0;
            tag_a[i] = '0;
        end

        vecs[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'h3, 64'h0, 1'b1};
        vecs[1] = '{1, 64'h5, 64'h7, 1'b1, 4'hA, 64'hD, 1'b0};
        vecs[2] = '{2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'hF, 64'h1, 1'b1};
        vecs[3] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'h0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{0, 64'h0, 64'h0, 1'b0, 4'h5, 64'h0, 1'b0};
        vecs[5] = '{2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 4'h9,
                    64'h2222_2222_2222_2211, 1'b0};

        // Reset state with every requester asking.
        @(negedge clk);
        check("rst_ready", reqReady, 0);
        check("rst_valid", respValid, 0);
        check("rst_idle", idle, 1);
        check("rst_sum", respSum, 0);
        check("rst_cout", respCOut, 0);
        check("rst_id", respId, 0);
        check("rst_tag", respTag, 0);
        rst_n    = 1'b1;
        reqValid = '0;

        // Single-request vectors, one-cycle latency, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            respReady               = 1'b1;
            in1_a[vecs[v].req]      = vecs[v].a;
            in2_a[vecs[v].req]      = vecs[v].b;
            reqCIn                  = '0;
            reqCIn[vecs[v].req]     = vecs[v].cin;
            tag_a[vecs[v].req]      = vecs[v].tag;
            reqValid                = N'(1) << vecs[v].req;
            #1;
            check($sformatf("v%0d_ready", v), reqReady, N'(1) << vecs[v].req);
            @(negedge clk);
            reqValid = '0;
            check($sformatf("v%0d_valid", v), respValid, 1);
            check($sformatf("v%0d_sum", v), respSum, vecs[v].sum);
            check($sformatf("v%0d_cout", v), respCOut, vecs[v].cout);
            check($sformatf("v%0d_id", v), respId, vecs[v].req);
            check($sformatf("v%0d_tag", v), respTag, vecs[v].tag);
            @(negedge clk);
            check($sformatf("v%0d_idle", v), idle, 1);
        end
        reqCIn = '0;

        // All requesters held: round-robin 0,1,2,3,... one transfer per cycle.
        do_reset();
        for (int i = 0; i < N; i++) begin
            in1_a[i] = 64'(i * 100);
            in2_a[i] = 64'h1;
            tag_a[i] = TW'(8 + i);
        end
        respReady = 1'b1;
        reqValid  = '1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check($sformatf("rr%0d_ready", k), reqReady, N'(1) << (k % N));
            if (k > 0) begin
                check($sformatf("rr%0d_valid", k), respValid, 1);
                check($sformatf("rr%0d_id", k), respId, (k - 1) % N);
                check($sformatf("rr%0d_tag", k), respTag, 8 + (k - 1) % N);
                check($sformatf("rr%0d_sum", k), respSum, ((k - 1) % N) * 100 + 1);
            end
            @(negedge clk);
        end
        reqValid = '0;
        @(negedge clk);
        check("rr_drain_idle", idle, 1);

        // Back-pressure: two transfers fill the FIFO, then everything stalls.
        do_reset();
        in1_a[1] = 64'd10; in2_a[1] = 64'd1; tag_a[1] = 4'h6;
        in1_a[2] = 64'd20; in2_a[2] = 64'd2; tag_a[2] = 4'h7;
        reqValid = 4'b0110;
        #1;
        check("bp_ready1", reqReady, 4'b0010);
        @(negedge clk);
        check("bp_ready2", reqReady, 4'b0100);
        check("bp_head_a", respId, 1);
        @(negedge clk);
        check("bp_full_ready", reqReady, 0);
        check("bp_full_idle", idle, 0);
        check("bp_head_b", respId, 1);
        check("bp_sum_b", respSum, 11);
        @(negedge clk);
        check("bp_head_c", respId, 1);
        check("bp_sum_c", respSum, 11);
        check("bp_tag_c", respTag, 4'h6);
        reqValid  = '0;
        respReady = 1'b1;
        @(negedge clk);
        check("bp_second_id", respId, 2);
        check("bp_second_sum", respSum, 22);
        check("bp_second_tag", respTag, 4'h7);
        @(negedge clk);
        check("bp_empty", respValid, 0);

        // Pointer at 2 with only req0 and req3 asking: req3 wins first.
        do_reset();
        respReady = 1'b1;
        reqValid  = 4'b0010;
        @(negedge clk);
        tag_a[0] = 4'hA;
        tag_a[3] = 4'hB;
        reqValid = 4'b1001;
        #1;
        check("skip_ready3", reqReady, 4'b1000);
        @(negedge clk);
        check("skip_id3", respId, 3);
        check("skip_tag3", respTag, 4'hB);
        check("skip_ready0", reqReady, 4'b0001);
        @(negedge clk);
        reqValid = '0;
        check("skip_id0", respId, 0);
        check("skip_tag0", respTag, 4'hA);
        @(negedge clk);
        check("skip_idle", idle, 1);

        // Push and pop on the same edge at count=1.
        do_reset();
        in1_a[0] = 64'd0; in2_a[0] = 64'd5; tag_a[0] = 4'h1;
        in1_a[2] = 64'd3; in2_a[2] = 64'd4; tag_a[2] = 4'h2;
        reqValid = 4'b0001;
        @(negedge clk);
        check("pp_first_sum", respSum, 5);
        reqValid  = 4'b0100;
        respReady = 1'b1;
        @(negedge clk);
        reqValid = '0;
        check("pp_valid", respValid, 1);
        check("pp_id", respId, 2);
        check("pp_sum", respSum, 7);
        check("pp_tag", respTag, 4'h2);
        @(negedge clk);
        check("pp_no_dup", respValid, 0);

        // Reset while the FIFO holds two results.
        do_reset();
        tag_a[1] = 4'h7;
        tag_a[2] = 4'h7;
        reqValid = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        check("mr_full", respValid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", respValid, 0);
        check("mr_idle", idle, 1);
        check("mr_ready", reqReady, 0);
        check("mr_tag", respTag, 0);
        tag_a[0] = 4'hC; tag_a[1] = 4'hD; tag_a[2] = 4'hE; tag_a[3] = 4'hF;
        reqValid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_after_valid", respValid, 0);
        check("mr_first_grant", reqReady, 4'b0001);
        respReady = 1'b1;
        @(negedge clk);
        reqValid = '0;
        check("mr_new_id", respId, 0);
        check("mr_new_tag", respTag, 4'hC);
        @(negedge clk);
        check("mr_end_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
